// File: rtl/traffic_pkg.sv
// Shared types and light encodings for the intersection phase scheduler.
// decode_lights turns a phase and approach into the 12-bit lamp word.
package traffic_pkg;

  localparam int NUM_DIR = 4;

  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;

  typedef enum logic [1:0] {
    ALL_RED,
    GREEN,
    YELLOW,
    PED_WALK
  } phase_t;

  function automatic logic [3*NUM_DIR-1:0] decode_lights(input phase_t st, input logic [1:0] dir);
    logic [3*NUM_DIR-1:0] l;
    int base;
    l = {NUM_DIR{LIGHT_RED}};
    base = 3 * int'(dir);
    if (st == GREEN) begin
      l[base +: 3] = LIGHT_GREEN;
    end else if (st == YELLOW) begin
      l[base +: 3] = LIGHT_YELLOW;
    end
    return l;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester after 'last',
// with 'last' itself considered only at the end of the rotation.
module rr_pick
  import traffic_pkg::*;
(
  input  logic [NUM_DIR-1:0] req,
  input  logic [1:0]         last,
  output logic [1:0]         grant_dir,
  output logic               any
);

  logic [1:0]         cand [NUM_DIR];
  logic [NUM_DIR-1:0] hit;

  for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_cand
    assign cand[gi] = last + 2'(gi + 1);
    assign hit[gi]  = req[cand[gi]];
  end

  // Scan from the farthest candidate down so the nearest one wins.
  always_comb begin
    grant_dir = last;
    for (int i = NUM_DIR - 1; i >= 0; i--) begin
      if (hit[i]) grant_dir = cand[i];
    end
  end

  assign any = |req;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Actuated 4-approach phase scheduler: round-robin greens with min/max timing,
// emergency preemption and a latched pedestrian all-red walk phase.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int T_MIN_GREEN = 8,
  parameter int T_MAX_GREEN = 20,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 2,
  parameter int T_WALK      = 6,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_DIR-1:0]     veh_req,
  input  logic                   ped_req,
  input  logic                   emerg_req,
  input  logic [1:0]             emerg_dir,
  output logic [3*NUM_DIR-1:0]   signal_lights,
  output logic                   ped_walk,
  output logic [1:0]             active_dir
);

  phase_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [1:0]           dir_reg, dir_next;
  logic                 ped_pending_reg, ped_pending_next;
  logic [3*NUM_DIR-1:0] lights_reg;
  logic                 walk_reg;

  logic [NUM_DIR-1:0]   dir_mask;
  logic [1:0]           rr_grant;
  logic                 rr_any;
  logic                 other;

  rr_pick u_rr_pick (
    .req       (veh_req),
    .last      (dir_reg),
    .grant_dir (rr_grant),
    .any       (rr_any)
  );

  assign dir_mask = NUM_DIR'(1) << dir_reg;
  assign other    = (emerg_req && (emerg_dir != dir_reg)) || ped_pending_reg
                    || (|(veh_req & ~dir_mask));

  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    case (state_reg)
      ALL_RED: begin
        if (cnt_reg >= CNT_W'(T_ALLRED - 1)) begin
          if (emerg_req) begin
            state_next = GREEN;
            dir_next   = emerg_dir;
          end else if (ped_pending_reg) begin
            state_next = PED_WALK;
          end else if (rr_any) begin
            state_next = GREEN;
            dir_next   = rr_grant;
          end
        end
      end
      GREEN: begin
        // An emergency for this approach pins the green with no timeout.
        if (emerg_req) begin
          if (emerg_dir != dir_reg) state_next = YELLOW;
        end else if (other && ((cnt_reg >= CNT_W'(T_MIN_GREEN - 1) && !veh_req[dir_reg])
                               || (cnt_reg >= CNT_W'(T_MAX_GREEN - 1)))) begin
          state_next = YELLOW;
        end
      end
      YELLOW: begin
        if (cnt_reg >= CNT_W'(T_YELLOW - 1)) state_next = ALL_RED;
      end
      PED_WALK: begin
        if (cnt_reg >= CNT_W'(T_WALK - 1)) state_next = ALL_RED;
      end
      default: state_next = ALL_RED;
    endcase

    if (state_next != state_reg) begin
      cnt_next = '0;
    end else if (&cnt_reg) begin
      cnt_next = cnt_reg;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end

    if (state_reg == PED_WALK) begin
      ped_pending_next = ped_pending_reg;
    end else if (state_next == PED_WALK) begin
      ped_pending_next = 1'b0;
    end else begin
      ped_pending_next = ped_pending_reg | ped_req;
    end
  end

  // Lamp outputs are decoded from the next state so they flip on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ALL_RED;
      cnt_reg         <= '0;
      dir_reg         <= 2'd3;
      ped_pending_reg <= 1'b0;
      lights_reg      <= {NUM_DIR{LIGHT_RED}};
      walk_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      dir_reg         <= dir_next;
      ped_pending_reg <= ped_pending_next;
      lights_reg      <= decode_lights(state_next, dir_next);
      walk_reg        <= (state_next == PED_WALK);
    end
  end

  assign signal_lights = lights_reg;
  assign ped_walk      = walk_reg;
  assign active_dir    = dir_reg;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: directed phase sequences queued as expected phases, a monitor
// pops one entry per observed output change; invariants checked every cycle.
module tb_traffic_phase_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  veh_req = 4'b0000;
  logic        ped_req = 1'b0;
  logic        emerg_req = 1'b0;
  logic [1:0]  emerg_dir = 2'd0;
  logic [11:0] signal_lights;
  logic        ped_walk;
  logic [1:0]  active_dir;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b1;

  localparam logic [11:0] AR = 12'h924;

  always #5 clk = ~clk;

  traffic_phase_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .veh_req       (veh_req),
    .ped_req       (ped_req),
    .emerg_req     (emerg_req),
    .emerg_dir     (emerg_dir),
    .signal_lights (signal_lights),
    .ped_walk      (ped_walk),
    .active_dir    (active_dir)
  );

  typedef struct {
    logic [11:0] l;
    logic        w;
    logic [1:0]  d;
    int          dur;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [11:0] lg(input int d);
    logic [11:0] v;
    v = AR;
    v[3*d +: 3] = 3'b001;
    return v;
  endfunction

  function automatic logic [11:0] ly(input int d);
    logic [11:0] v;
    v = AR;
    v[3*d +: 3] = 3'b010;
    return v;
  endfunction

  task automatic push(input logic [11:0] l, input logic w, input logic [1:0] d, input int dur);
    exp_t e;
    e.l = l; e.w = w; e.d = d; e.dur = dur;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [11:0] m_cur_l = '0;
  logic        m_cur_w = 1'b0;
  int          m_cur_dur = 0;
  int          m_run_len = 0;
  bit          m_have_cur = 1'b0;
  bit          m_in_reset = 1'b0;

  task automatic start_phase(input bit chk_dur);
    exp_t e;
    if (chk_dur && m_have_cur && m_cur_dur != 0) check("phase_len", m_run_len, m_cur_dur);
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_phase: got lights %03h walk %0b, expected no change",
               signal_lights, ped_walk);
      m_cur_dur = 0;
    end else begin
      e = exp_q.pop_front();
      check("lights", int'(signal_lights), int'(e.l));
      check("ped_walk", int'(ped_walk), int'(e.w));
      check("active_dir", int'(active_dir), int'(e.d));
      $display("[TB] phase lights=%03h walk=%0b dir=%0d", signal_lights, ped_walk, active_dir);
      m_cur_dur = e.dur;
    end
    m_cur_l    = signal_lights;
    m_cur_w    = ped_walk;
    m_run_len  = 1;
    m_have_cur = 1'b1;
  endtask

  initial begin : monitor
    logic r;
    forever begin
      @(posedge clk);
      r = rst;
      @(negedge clk);
      if (!mon_en) begin
        m_have_cur = 1'b0;
      end else if (r) begin
        if (!m_in_reset) begin
          start_phase(1'b0);
          m_in_reset = 1'b1;
        end else begin
          m_run_len = 1;
        end
      end else begin
        m_in_reset = 1'b0;
        if (signal_lights !== m_cur_l || ped_walk !== m_cur_w) start_phase(1'b1);
        else m_run_len++;
      end
    end
  end

  // ---------------- safety invariants ----------------
  initial begin : invariants
    logic        r;
    logic [11:0] prev;
    bit          prev_ok;
    bit          started;
    int          nonred;
    int          shown;
    bit          bad;
    logic [2:0]  c;
    logic [2:0]  p;
    prev_ok = 1'b0; started = 1'b0; shown = 0; prev = '0;
    forever begin
      @(posedge clk);
      r = rst;
      @(negedge clk);
      if (r) started = 1'b1;
      if (started) begin
        bad = 1'b0;
        nonred = 0;
        for (int i = 0; i < 4; i++) begin
          c = signal_lights[3*i +: 3];
          if (c != 3'b001 && c != 3'b010 && c != 3'b100) bad = 1'b1;
          if (c != 3'b100) nonred++;
          if (!r && prev_ok) begin
            p = prev[3*i +: 3];
            if (p == 3'b001 && c != 3'b001 && c != 3'b010) bad = 1'b1;
            if (p == 3'b010 && c != 3'b010 && !(signal_lights == AR && !ped_walk)) bad = 1'b1;
          end
        end
        if (nonred > 1) bad = 1'b1;
        if (ped_walk && nonred != 0) bad = 1'b1;
        tests++;
        if (bad) begin
          fails++;
          if (shown < 20) begin
            shown++;
            $display("FAIL invariant: lights %03h walk %0b after %03h, required safe sequence",
                     signal_lights, ped_walk, prev);
          end
        end
        prev = signal_lights;
        prev_ok = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_out(input string name, input logic [11:0] l, input logic w, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (signal_lights === l && ped_walk === w) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s: timeout with lights %03h walk %0b, expected lights %03h walk %0b",
               name, signal_lights, ped_walk, l, w);
    end
  endtask

  initial begin : stimulus
    // Reset, then approach 2 alone: 2 all-red cycles then resting green.
    veh_req = 4'b0100;
    push(AR, 1'b0, 2'd3, 2);
    push(lg(2), 1'b0, 2'd2, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_out("wait_g2", lg(2), 1'b0, 20);
    repeat (30) @(negedge clk);

    // Move to approach 0, then hold 1001 for a max-out green.
    push(ly(2), 1'b0, 2'd2, 3);
    push(AR, 1'b0, 2'd2, 2);
    push(lg(0), 1'b0, 2'd0, 20);
    push(ly(0), 1'b0, 2'd0, 3);
    push(AR, 1'b0, 2'd0, 2);
    push(lg(3), 1'b0, 2'd3, 8);
    veh_req = 4'b0001;
    wait_out("wait_g0", lg(0), 1'b0, 20);
    veh_req = 4'b1001;

    // Approach 3 gaps out toward 1; approach 1 loses demand at green cycle 3.
    push(ly(3), 1'b0, 2'd3, 3);
    push(AR, 1'b0, 2'd3, 2);
    push(lg(1), 1'b0, 2'd1, 8);
    push(ly(1), 1'b0, 2'd1, 3);
    push(AR, 1'b0, 2'd1, 2);
    push(lg(0), 1'b0, 2'd0, 20);
    wait_out("wait_g3", lg(3), 1'b0, 40);
    veh_req = 4'b0010;
    wait_out("wait_g1", lg(1), 1'b0, 40);
    repeat (2) @(negedge clk);
    veh_req = 4'b0001;

    // Pedestrian pulse during a contested-only-by-ped green; re-press in walk ignored.
    push(ly(0), 1'b0, 2'd0, 3);
    push(AR, 1'b0, 2'd0, 2);
    push(AR, 1'b1, 2'd0, 6);
    push(AR, 1'b0, 2'd0, 2);
    push(lg(0), 1'b0, 2'd0, 2);
    wait_out("wait_g0b", lg(0), 1'b0, 40);
    repeat (4) @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    wait_out("wait_walk", AR, 1'b1, 60);
    repeat (2) @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;

    // Emergency for approach 2 at green cycle 2 of approach 0.
    push(ly(0), 1'b0, 2'd0, 3);
    push(AR, 1'b0, 2'd0, 2);
    push(lg(2), 1'b0, 2'd2, 0);
    wait_out("wait_g0c", lg(0), 1'b0, 40);
    @(negedge clk);
    emerg_req = 1'b1;
    emerg_dir = 2'd2;
    veh_req   = 4'b1011;
    ped_req   = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    wait_out("wait_g2e", lg(2), 1'b0, 20);
    push(ly(2), 1'b0, 2'd2, 3);
    push(AR, 1'b0, 2'd2, 2);
    push(AR, 1'b1, 2'd2, 6);
    push(AR, 1'b0, 2'd2, 2);
    push(lg(3), 1'b0, 2'd3, 8);
    repeat (30) @(negedge clk);
    emerg_req = 1'b0;

    // Reset mid-yellow clears the pending pedestrian request.
    push(ly(3), 1'b0, 2'd3, 0);
    push(AR, 1'b0, 2'd3, 2);
    push(lg(0), 1'b0, 2'd0, 0);
    wait_out("wait_g3b", lg(3), 1'b0, 60);
    veh_req = 4'b0001;
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    wait_out("wait_y3", ly(3), 1'b0, 20);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_lights", int'(signal_lights), int'(AR));
    check("rst_walk", int'(ped_walk), 0);
    wait_out("wait_g0d", lg(0), 1'b0, 20);
    veh_req = 4'b0000;
    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    // Random soak: only the invariants are checked here.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(posedge clk);
      #1;
      veh_req = 4'($urandom_range(0, 15));
      ped_req = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) emerg_req = ~emerg_req;
      if ($urandom_range(0, 99) == 0) emerg_dir = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 999) == 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
